// File: rtl/decode_data_stream.sv
// WS2812B-style single-wire NRZ decoder: measures high/low pulse widths and assembles 24-bit pixels LSB-first.
// Optional pulse-width fault detection is compiled in when DSTREAM_ERR_EN is defined.
module decode_data_stream #(
    parameter int THRESH     = 24,
    parameter int MIN_HIGH   = 8,
    parameter int MAX_HIGH   = 48,
    parameter int GAP_CYCLES = 2000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        datastream,
    output logic [23:0] pixel,
    output logic        pixel_valid,
    output logic [8:0]  pixel_count,
    output logic        frame_done,
    output logic        err
);
    typedef enum logic [1:0] {GAP, HIGH, LOW, FAULT} state_t;

    localparam logic [10:0] CNT_SAT  = 11'd2047;
    localparam logic [10:0] THRESH_C = 11'(THRESH);
    localparam logic [10:0] GAP_LAST = 11'(GAP_CYCLES - 1);
`ifdef DSTREAM_ERR_EN
    localparam logic [10:0] MIN_C    = 11'(MIN_HIGH);
    localparam logic [10:0] MAX_C    = 11'(MAX_HIGH);
`endif

    state_t      state_reg, state_next;
    logic        sync1_reg, sync2_reg, prev_reg;
    logic [10:0] high_cnt_reg, low_cnt_reg;
    logic [4:0]  bitidx_reg;
    logic [23:0] shift_reg, pixel_reg;
    logic [8:0]  pixel_count_reg;
    logic        load_reg, pixel_valid_reg, frame_done_reg;
    logic        rise, fall, gap_hit;
    logic        start_high, start_frame, bit_done, close_frame, err_set;

    assign rise    = sync2_reg & ~prev_reg;
    assign fall    = ~sync2_reg & prev_reg;
    // low_cnt_reg counts low cycles before this one, so this is the GAP_CYCLES-th low cycle
    assign gap_hit = (low_cnt_reg >= GAP_LAST);

    always_comb begin
        state_next  = state_reg;
        start_high  = 1'b0;
        start_frame = 1'b0;
        bit_done    = 1'b0;
        close_frame = 1'b0;
        err_set     = 1'b0;
        case (state_reg)
            GAP: begin
                if (rise) begin
                    state_next  = HIGH;
                    start_high  = 1'b1;
                    start_frame = 1'b1;
                end
            end
            HIGH: begin
`ifdef DSTREAM_ERR_EN
                if ((fall && high_cnt_reg < MIN_C) || (!fall && high_cnt_reg >= MAX_C)) begin
                    state_next = FAULT;
                    err_set    = 1'b1;
                end else
`endif
                if (fall) begin
                    state_next = LOW;
                    bit_done   = 1'b1;
                end
            end
            LOW: begin
                if (gap_hit) begin
                    // gap wins; a coincident rise immediately opens the next frame
                    close_frame = 1'b1;
                    if (rise) begin
                        state_next  = HIGH;
                        start_high  = 1'b1;
                        start_frame = 1'b1;
                    end else begin
                        state_next = GAP;
                    end
                end else if (rise) begin
                    state_next = HIGH;
                    start_high = 1'b1;
                end
            end
            FAULT: begin
                if (!sync2_reg && gap_hit) state_next = GAP;
            end
            default: state_next = GAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) state_reg <= GAP;
        else        state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_reg       <= 1'b0;
            sync2_reg       <= 1'b0;
            prev_reg        <= 1'b0;
            high_cnt_reg    <= '0;
            low_cnt_reg     <= '0;
            bitidx_reg      <= '0;
            shift_reg       <= '0;
            pixel_reg       <= '0;
            pixel_count_reg <= '0;
            load_reg        <= 1'b0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= 1'b0;
        end else begin
            sync1_reg       <= datastream;
            sync2_reg       <= sync1_reg;
            prev_reg        <= sync2_reg;
            load_reg        <= 1'b0;
            pixel_valid_reg <= 1'b0;
            frame_done_reg  <= close_frame;

            // the rising-edge cycle is itself the first high cycle
            if (start_high)                  high_cnt_reg <= 11'd1;
            else if (high_cnt_reg != CNT_SAT) high_cnt_reg <= high_cnt_reg + 11'd1;

            if (sync2_reg)                   low_cnt_reg <= '0;
            else if (low_cnt_reg != CNT_SAT) low_cnt_reg <= low_cnt_reg + 11'd1;

            if (start_frame) pixel_count_reg <= '0;

            if (bit_done) begin
                shift_reg[bitidx_reg] <= (high_cnt_reg >= THRESH_C);
                if (bitidx_reg == 5'd23) begin
                    bitidx_reg <= '0;
                    load_reg   <= 1'b1;
                end else begin
                    bitidx_reg <= bitidx_reg + 5'd1;
                end
            end
            if (close_frame || err_set) bitidx_reg <= '0;

            if (load_reg) begin
                pixel_reg       <= shift_reg;
                pixel_valid_reg <= 1'b1;
                if (pixel_count_reg != 9'd511) pixel_count_reg <= pixel_count_reg + 9'd1;
            end
        end
    end

`ifdef DSTREAM_ERR_EN
    logic err_reg;
    always_ff @(posedge clk) begin
        if (!reset) err_reg <= 1'b0;
        else        err_reg <= err_set;
    end
    assign err = err_reg;
`else
    assign err = 1'b0;
`endif

    assign pixel       = pixel_reg;
    assign pixel_valid = pixel_valid_reg;
    assign pixel_count = pixel_count_reg;
    assign frame_done  = frame_done_reg;
endmodule

// File: tb/tb_decode_data_stream.sv
// Randomized scoreboard bench for decode_data_stream: a pulse-level model predicts pixels, counts, latency and frame ends.
`timescale 1ns/1ps
module tb_decode_data_stream;
    localparam int THRESH     = 24;
    localparam int MIN_HIGH   = 8;
    localparam int MAX_HIGH   = 48;
    localparam int GAP_CYCLES = 2000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        datastream = 1'b0;
    logic [23:0] pixel;
    logic        pixel_valid;
    logic [8:0]  pixel_count;
    logic        frame_done;
    logic        err;

    decode_data_stream #(
        .THRESH(THRESH), .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .datastream(datastream), .pixel(pixel),
        .pixel_valid(pixel_valid), .pixel_count(pixel_count), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [23:0] px;
        int          cnt;
        longint      cyc;
    } px_exp_t;

    px_exp_t     px_q[$];
    int          fd_q[$];
    px_exp_t     mon_e;
    int          mon_fd;
    int          checks = 0;
    int          errors = 0;
    int          err_exp = 0;
    int          err_seen = 0;
    longint      cyc = 0;

    logic [23:0] m_word = '0;
    logic [23:0] m_last = '0;
    int          m_nbits = 0;
    int          m_pixels = 0;
    bit          m_open = 1'b0;
    bit          m_fault = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (pixel_valid) begin
            if (px_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pixel_valid_unexpected: got pixel %06h, required no pulse", pixel);
            end else begin
                mon_e = px_q.pop_front();
                check("pixel", 32'(pixel), 32'(mon_e.px));
                check("pixel_count_at_valid", 32'(pixel_count), 32'(mon_e.cnt));
                check("decode_latency_cycle", 32'(cyc), 32'(mon_e.cyc));
                $display("pixel_valid: pixel=%06h count=%0d cycle=%0d", pixel, pixel_count, cyc);
            end
        end
        if (frame_done) begin
            if (fd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_done_unexpected: got pulse with count %0d, required no pulse", pixel_count);
            end else begin
                mon_fd = fd_q.pop_front();
                check("pixel_count_at_frame_done", 32'(pixel_count), 32'(mon_fd));
                $display("frame_done: count=%0d cycle=%0d", pixel_count, cyc);
            end
        end
        if (err) begin
            err_seen++;
            $display("err pulse at cycle %0d", cyc);
        end
    end

    // Reference model: each high pulse is one bit, classified by width; 24 bits make a pixel.
    function automatic void model_pulse(input int h, input longint fall_cyc);
        px_exp_t e;
        if (m_fault) return;
`ifdef DSTREAM_ERR_EN
        if (h < MIN_HIGH || h > MAX_HIGH) begin
            err_exp++;
            m_fault = 1'b1;
            m_open  = 1'b0;
            m_nbits = 0;
            m_word  = '0;
            return;
        end
`endif
        m_open = 1'b1;
        m_word[m_nbits] = (h >= THRESH);
        m_nbits++;
        if (m_nbits == 24) begin
            m_pixels++;
            m_last = m_word;
            e.px  = m_word;
            e.cnt = (m_pixels > 511) ? 511 : m_pixels;
            e.cyc = fall_cyc + 4;
            px_q.push_back(e);
            m_nbits = 0;
            m_word  = '0;
        end
    endfunction

    task automatic send_pulse(input int h, input int l);
        datastream = 1'b1;
        repeat (h) @(negedge clk);
        datastream = 1'b0;
        model_pulse(h, cyc);
        repeat (l) @(negedge clk);
    endtask

    // mode 0: nominal WS2812B timing, 1: random legal widths, 2: widths straddling THRESH
    task automatic send_bits(input logic [23:0] value, input int nb, input int mode);
        int h;
        int l;
        for (int i = 0; i < nb; i++) begin
            case (mode)
                0: begin
                    h = value[i] ? 33 : 17;
                    l = value[i] ? 19 : 35;
                end
                1: begin
                    h = value[i] ? int'($urandom_range(MAX_HIGH, THRESH)) : int'($urandom_range(THRESH - 1, MIN_HIGH));
                    l = int'($urandom_range(60, 6));
                end
                default: begin
                    h = value[i] ? THRESH : THRESH - 1;
                    l = int'($urandom_range(40, 6));
                end
            endcase
            send_pulse(h, l);
        end
    endtask

    task automatic send_gap();
        if (m_open && !m_fault) fd_q.push_back((m_pixels > 511) ? 511 : m_pixels);
        m_open   = 1'b0;
        m_fault  = 1'b0;
        m_nbits  = 0;
        m_word   = '0;
        m_pixels = 0;
        repeat (GAP_CYCLES + 20) @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b0;
        datastream = 1'b0;
        repeat (4) @(negedge clk);
        check("reset_pixel", 32'(pixel), 32'd0);
        check("reset_pixel_count", 32'(pixel_count), 32'd0);
        check("reset_pixel_valid", 32'(pixel_valid), 32'd0);
        check("reset_frame_done", 32'(frame_done), 32'd0);
        check("reset_err", 32'(err), 32'd0);
        reset    = 1'b1;
        m_open   = 1'b0;
        m_fault  = 1'b0;
        m_nbits  = 0;
        m_word   = '0;
        m_pixels = 0;
        m_last   = '0;
    endtask

    initial begin
        logic [23:0] v;
        int n;

        do_reset();

        send_bits(24'h00F060, 24, 0);
        send_gap();
        check("pixel_after_single_frame", 32'(pixel), 32'h00F060);
        check("count_after_single_frame", 32'(pixel_count), 32'd1);

        for (int p = 0; p < 9; p++) send_bits(24'h00B000, 24, 0);
        send_gap();
        check("count_after_nine_pixels", 32'(pixel_count), 32'd9);

        for (int f = 0; f < 3; f++) begin
            n = int'($urandom_range(4, 1));
            for (int p = 0; p < n; p++) begin
                v = 24'($urandom);
                send_bits(v, 24, 1);
            end
            send_gap();
        end

        v = 24'($urandom);
        send_bits(v, 24, 2);
        send_gap();

        v = 24'($urandom);
        send_bits(v, 12, 1);
        send_gap();
        check("pixel_held_after_partial", 32'(pixel), 32'(m_last));

`ifdef DSTREAM_ERR_EN
        v = 24'($urandom);
        send_bits(v, 5, 1);
        send_pulse(4, 30);
        send_bits(v, 3, 1);
        send_gap();
        send_bits(24'h5A0FC3, 24, 1);
        send_gap();
        send_bits(v, 7, 1);
        send_pulse(MAX_HIGH + 6, 20);
        send_gap();
        send_bits(24'h13579B, 24, 0);
        send_gap();
`endif

        v = 24'($urandom);
        send_bits(v, 10, 1);
        do_reset();
        send_bits(24'hB05000, 24, 0);
        send_gap();
        check("pixel_after_reset_recovery", 32'(pixel), 32'hB05000);

        repeat (20) @(negedge clk);
        check("pixel_queue_drained", 32'(px_q.size()), 32'd0);
        check("frame_queue_drained", 32'(fd_q.size()), 32'd0);
        check("err_pulse_count", 32'(err_seen), 32'(err_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_data_stream.md
DECODE_DATA_STREAM -- requirements
Module: decode_data_stream

Interface
REQ-001 Parameter THRESH, default 24: high-pulse length in clk cycles at or above which a bit decodes as 1; below it, the bit decodes as 0.
REQ-002 Parameter MIN_HIGH, default 8: shortest legal high pulse in cycles.
REQ-003 Parameter MAX_HIGH, default 48: longest legal high pulse in cycles.
REQ-004 Parameter GAP_CYCLES, default 2000: low time in cycles that marks a frame latch/reset gap.
REQ-005 clk  input  1  40 MHz system clock; all logic on posedge.
REQ-006 reset  input  1  synchronous, active-low reset.
REQ-007 datastream  input  1  asynchronous single-wire WS2812B-style NRZ pulse stream.
REQ-008 pixel  output  24  last decoded 24-bit color word.
REQ-009 pixel_valid  output  1  one-cycle pulse when pixel is updated.
REQ-010 pixel_count  output  9  pixels completed in the current frame, saturating at 511.
REQ-011 frame_done  output  1  one-cycle pulse when a gap ends a frame that contained at least one bit.
REQ-012 err  output  1  one-cycle pulse on a pulse-width violation (DSTREAM_ERR_EN only).

Function
REQ-013 datastream shall pass through a two-flop synchronizer before any use; all edges are detected on the synchronized signal.
REQ-014 FSM states: GAP (line low, frame boundary established), HIGH (measuring high time), LOW (measuring low time after a bit), and FAULT (discarding until the next gap).
REQ-015 GAP->HIGH on a synchronized rising edge; the width counter clears, and pixel_count clears if the previous frame was closed.
REQ-016 HIGH->LOW on a falling edge; the bit decodes as (high count >= THRESH) and is written to bit position bitidx.
REQ-017 Bits shall assemble LSB-first: the first bit of a pixel goes to pixel[0] and the 24th goes to pixel[23].
REQ-018 On the falling edge of the 24th bit, the next clk cycle shall load pixel, pulse pixel_valid, increment pixel_count, and clear bitidx.
REQ-019 LOW->HIGH on a rising edge occurs before the low count reaches GAP_CYCLES.
REQ-020 LOW->GAP when the low count reaches GAP_CYCLES: frame_done pulses in that cycle and any partial pixel (bitidx != 0) is discarded without a pixel_valid.
REQ-021 Width counters shall be 11 bits and saturate at 2047 rather than wrap.
REQ-022 A line held high indefinitely shall not produce pixel_valid.
REQ-023 A falling edge and a gap in the same cycle cannot occur; a rising edge in the cycle the gap count is reached shall be treated as gap first, then a new frame start.
REQ-024 pixel shall hold its value between pixel_valid pulses.
REQ-025 Decode latency from the raw falling edge of the 24th bit to pixel_valid shall be 4 clk cycles (2 synchronizer, 1 edge detect, 1 load).

Reset
REQ-026 While reset is low at a posedge, the FSM shall enter GAP; pixel, pixel_count, bitidx and the counters clear to 0; and pixel_valid, frame_done and err are 0.
REQ-027 Reset asserted mid-pixel shall discard the partial pixel and emit no pulses.
REQ-028 After reset deassertion, the line is treated as already in a gap, so the first rising edge starts a frame.

Configuration
REQ-029 With macro DSTREAM_ERR_EN defined, a high pulse shorter than MIN_HIGH or longer than MAX_HIGH shall pulse err, discard the partial pixel, and enter FAULT.
REQ-030 FAULT exits to GAP only after GAP_CYCLES of continuous low, with no frame_done pulse.
REQ-031 Without DSTREAM_ERR_EN, err is tied to 0, FAULT is unreachable, and every high pulse is classified by THRESH alone.

Verification
REQ-032 Reset released, then 24 bits encoding 24'h00F060 (T0H 17/T0L 35, T1H 33/T1L 19 cycles), then 2000 low cycles -> one pixel_valid with pixel=24'h00F060, pixel_count=1, then one frame_done.
REQ-033 9 back-to-back pixels 24'h00B000 followed by a gap -> 9 pixel_valid pulses, pixel_count=9, one frame_done.
REQ-034 12 valid bits then 2000 low cycles -> no pixel_valid, frame_done pulses, and pixel still holds its previous value.
REQ-035 With DSTREAM_ERR_EN, a 4-cycle high pulse mid-pixel -> err pulses once, no pixel_valid and no frame_done until the line has been low for 2000 cycles, and the next frame decodes correctly.
REQ-036 Reset pulled low after 10 bits, released, then a full pixel 24'hB05000 -> exactly one pixel_valid with pixel=24'hB05000.
REQ-037 High pulses of exactly 23 and 24 cycles -> the bits decode as 0 and 1 respectively.
